// File: rtl/core_seq_pkg.sv
// Shared types and constants for the systolic-core instruction sequencer.
// Bit map of the 35-bit inst word plus the FSM state encoding.
package core_seq_pkg;

  localparam int INST_W          = 35;
  localparam int ADDR_W          = 11;

  localparam int INST_CHOICE     = 34;
  localparam int INST_ACC        = 33;
  localparam int INST_CEN_PMEM   = 32;
  localparam int INST_WEN_PMEM   = 31;
  localparam int INST_A_PMEM_LSB = 20;
  localparam int INST_CEN_XMEM   = 19;
  localparam int INST_WEN_XMEM   = 18;
  localparam int INST_A_XMEM_LSB = 7;
  localparam int INST_OFIFO_RD   = 6;
  localparam int INST_IFIFO_WR   = 5;
  localparam int INST_IFIFO_RD   = 4;
  localparam int INST_L0_RD      = 3;
  localparam int INST_L0_WR      = 2;
  localparam int INST_EXECUTE    = 1;
  localparam int INST_LOAD       = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  typedef struct packed {
    logic              choice;
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_LOAD,
    S_WAIT,
    S_X_L0,
    S_EXEC,
    S_EDRAIN,
    S_OFIFO,
    S_ACC,
    S_FIN
  } state_t;

  typedef enum logic {
    PA_WR,
    PA_RD
  } pa_mode_t;

  // Splits a flat kernel index into {ki, kj}.
  function automatic logic [3:0] k_split(
    input logic [3:0] k,
    input int         ks
  );
    logic [1:0] ki;
    logic [1:0] kj;
    ki = 2'(k / 4'(ks));
    kj = 2'(k % 4'(ks));
    return {ki, kj};
  endfunction

endpackage

// File: rtl/core_seq_ctrl_psum_addr_gen.sv
// psum memory address generator: OFIFO write-back and ACC read addresses.
// Purely combinational; the top registers the result into inst.
module psum_addr_gen
  import core_seq_pkg::*;
#(
  parameter int IN_W = 6,
  parameter int KS   = 3
) (
  input  pa_mode_t          mode,
  input  logic [3:0]        kij,
  input  logic [5:0]        n,
  input  logic [1:0]        orow,
  input  logic [1:0]        ocol,
  input  logic [1:0]        ki,
  input  logic [1:0]        kj,
  output logic [ADDR_W-1:0] addr
);

  localparam int LEN_NIJ = IN_W * IN_W;

  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  always_comb begin
    k       = ADDR_W'(ki) * ADDR_W'(KS) + ADDR_W'(kj);
    row     = ADDR_W'(orow) + ADDR_W'(ki);
    col     = ADDR_W'(ocol) + ADDR_W'(kj);
    wr_addr = ADDR_W'(kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(n);
    rd_addr = k * ADDR_W'(LEN_NIJ)
            + row * ADDR_W'(IN_W) + col;
    addr    = (mode == PA_WR) ? wr_addr : rd_addr;
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Layer sequencer for the 8x8 systolic core: emits one registered
// 35-bit inst word per cycle for a full 3x3-kernel layer.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int                COL   = 8,
  parameter int                IN_W  = 6,
  parameter int                OUT_W = 4,
  parameter int                KS    = 3,
  parameter logic [ADDR_W-1:0] WBASE = 11'h400,
  parameter int                DRAIN = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              choice,
  output logic [INST_W-1:0] inst,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [3:0]        onij
);

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int LEN_KIJ  = KS * KS;
  localparam int ACC_END  = LEN_KIJ + 2;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nx;
  logic [3:0]  kij;
  logic [3:0]  kij_nx;
  logic [3:0]  o;
  logic [3:0]  o_nx;
  logic [3:0]  c;
  logic [3:0]  c_nx;

  inst_t       ins_nx;
  logic        core_reset_nx;
  logic        done_nx;
  logic        out_valid_nx;
  logic [3:0]  onij_nx;

  pa_mode_t          pa_mode;
  logic [1:0]        ki;
  logic [1:0]        kj;
  logic [1:0]        orow;
  logic [1:0]        ocol;
  logic [5:0]        n;
  logic [ADDR_W-1:0] pa_addr;

  assign pa_mode   = (state == S_ACC) ? PA_RD : PA_WR;
  assign n         = cnt - 6'd1;
  assign {ki, kj}  = k_split(c - 4'd1, KS);
  assign orow      = 2'(o / 4'(OUT_W));
  assign ocol      = 2'(o % 4'(OUT_W));

  psum_addr_gen #(
    .IN_W (IN_W),
    .KS   (KS)
  ) u_pa (
    .mode (pa_mode),
    .kij  (kij),
    .n    (n),
    .orow (orow),
    .ocol (ocol),
    .ki   (ki),
    .kj   (kj),
    .addr (pa_addr)
  );

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt + 6'd1;
    kij_nx        = kij;
    o_nx          = o;
    c_nx          = c;
    ins_nx        = inst_t'(INST_IDLE);
    ins_nx.choice = choice;
    core_reset_nx = 1'b0;
    done_nx       = 1'b0;
    out_valid_nx  = 1'b0;
    onij_nx       = onij;

    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = S_W_L0;
      end
      S_W_L0: begin
        if (cnt < 6'(COL)) begin
          ins_nx.cen_xmem = 1'b0;
          ins_nx.a_xmem   = WBASE
                          + ADDR_W'(kij) * ADDR_W'(COL)
                          + ADDR_W'(cnt);
        end
        ins_nx.l0_wr = (cnt != 6'd0);
        if (cnt == 6'(COL)) begin
          state_nx = S_LOAD;
          cnt_nx   = '0;
        end
      end
      S_LOAD: begin
        ins_nx.l0_rd = 1'b1;
        ins_nx.load  = 1'b1;
        if (cnt == 6'(COL - 1)) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == 6'(DRAIN - 1)) begin
          state_nx = S_X_L0;
          cnt_nx   = '0;
        end
      end
      S_X_L0: begin
        if (cnt < 6'(LEN_NIJ)) begin
          ins_nx.cen_xmem = 1'b0;
          ins_nx.a_xmem   = ADDR_W'(cnt);
        end
        ins_nx.l0_wr = (cnt != 6'd0);
        if (cnt == 6'(LEN_NIJ)) begin
          state_nx = S_EXEC;
          cnt_nx   = '0;
        end
      end
      S_EXEC: begin
        ins_nx.l0_rd   = 1'b1;
        ins_nx.execute = 1'b1;
        if (cnt == 6'(LEN_NIJ - 1)) begin
          state_nx = S_EDRAIN;
          cnt_nx   = '0;
        end
      end
      S_EDRAIN: begin
        if (cnt == 6'(LEN_NIJ - 1)) begin
          state_nx = S_OFIFO;
          cnt_nx   = '0;
        end
      end
      S_OFIFO: begin
        ins_nx.ofifo_rd = (cnt < 6'(LEN_NIJ));
        // Write-back trails the FIFO pop by one cycle.
        if (cnt != 6'd0) begin
          ins_nx.cen_pmem = 1'b0;
          ins_nx.wen_pmem = 1'b0;
          ins_nx.a_pmem   = pa_addr;
        end
        if (cnt == 6'(LEN_NIJ)) begin
          cnt_nx = '0;
          if (kij == 4'(LEN_KIJ - 1)) begin
            state_nx = S_ACC;
            kij_nx   = '0;
          end else begin
            state_nx = S_W_L0;
            kij_nx   = kij + 4'd1;
          end
        end
      end
      S_ACC: begin
        cnt_nx        = '0;
        c_nx          = c + 4'd1;
        core_reset_nx = (c == 4'd0);
        if (c >= 4'd1 && c <= 4'(LEN_KIJ)) begin
          ins_nx.cen_pmem = 1'b0;
          ins_nx.a_pmem   = pa_addr;
        end
        ins_nx.acc = (c >= 4'd2) && (c <= 4'(LEN_KIJ + 1));
        if (c == 4'(ACC_END)) begin
          out_valid_nx = 1'b1;
          onij_nx      = o;
          c_nx         = '0;
          o_nx         = o + 4'd1;
          if (o == 4'(LEN_ONIJ - 1)) state_nx = S_FIN;
        end
      end
      S_FIN: begin
        cnt_nx   = '0;
        done_nx  = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kij        <= '0;
      o          <= '0;
      c          <= '0;
      inst       <= INST_IDLE;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      onij       <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      kij        <= kij_nx;
      o          <= o_nx;
      c          <= c_nx;
      inst       <= ins_nx;
      core_reset <= core_reset_nx;
      busy       <= (state != S_IDLE);
      done       <= done_nx;
      out_valid  <= out_valid_nx;
      onij       <= onij_nx;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: expected memory accesses are
// queued by the stimulus and popped by a negedge monitor.
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        choice = 1'b0;
  logic [34:0] inst;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [3:0]  onij;
  inst_t       w;

  assign w = inst;

  core_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .choice     (choice),
    .inst       (inst),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .onij       (onij)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [10:0] xq[$];
  logic [11:0] pq[$];
  logic [3:0]  oq[$];

  bit mon_en = 0;
  int cyc = 0;
  int t_first = -1;
  int t_done = -1;
  int n_l0wr, n_load, n_exec, n_ofrd;
  int n_acc, n_crst, n_done, n_ififo, acc_run;
  logic prev_xrd = 1'b0;
  logic prev_ofrd = 1'b0;

  logic [10:0] exp5 [9];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_l0wr = 0; n_load = 0; n_exec = 0; n_ofrd = 0;
    n_acc = 0; n_crst = 0; n_done = 0; n_ififo = 0;
    acc_run = 0; t_first = -1; t_done = -1;
  endtask

  task automatic push_kij(input int k);
    for (int i = 0; i < 8; i++) xq.push_back(11'(11'h400 + k * 8 + i));
    for (int a = 0; a < 36; a++) xq.push_back(11'(a));
  endtask

  always @(negedge clk) begin
    logic [10:0] ex;
    logic [11:0] ep;
    logic [3:0]  eo;
    cyc++;
    if (mon_en) begin
      if (!w.cen_xmem) begin
        if (t_first < 0) t_first = cyc;
        if (xq.size() == 0) chk("xmem_extra", 1, 0);
        else begin
          ex = xq.pop_front();
          chk("xmem_rd", {w.wen_xmem, w.a_xmem}, {1'b1, ex});
        end
      end
      if (!w.cen_pmem) begin
        if (pq.size() == 0) chk("pmem_extra", 1, 0);
        else begin
          ep = pq.pop_front();
          chk("pmem", {w.wen_pmem, w.a_pmem}, ep);
        end
        if (!w.wen_pmem) chk("pmem_wr_lag", prev_ofrd, 1);
      end
      if (w.l0_wr) begin
        n_l0wr++;
        chk("l0_wr_lag", prev_xrd, 1);
      end
      if (w.load) n_load++;
      if (w.execute) n_exec++;
      if (w.ofifo_rd) n_ofrd++;
      if (w.ififo_wr || w.ififo_rd) n_ififo++;
      if (core_reset) begin
        n_crst++;
        acc_run = 0;
      end
      if (w.acc) begin
        n_acc++;
        acc_run++;
      end
      if (out_valid) begin
        chk("acc_len", acc_run, 9);
        if (oq.size() == 0) chk("ovalid_extra", 1, 0);
        else begin
          eo = oq.pop_front();
          chk("onij", onij, eo);
        end
      end
      if (done) begin
        n_done++;
        t_done = cyc;
      end
    end
    prev_xrd  = !w.cen_xmem;
    prev_ofrd = w.ofifo_rd;
  end

  initial begin
    int orow, ocol, ki, kj;
    exp5 = '{11'd7, 11'd44, 11'd81, 11'd121, 11'd158,
             11'd195, 11'd235, 11'd272, 11'd309};
    clr_counts();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst", inst, 35'h1_800C_0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_creset", core_reset, 0);
    chk("rst_onij", onij, 0);

    // Aborted run: reset lands in the middle of EXEC for kij 0.
    @(negedge clk);
    reset = 1'b1;
    push_kij(0);
    mon_en = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200 && !w.execute; i++) @(negedge clk);
    chk("exec_seen", w.execute, 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_inst", inst, 35'h1_800C_0000);
    chk("abort_busy", busy, 0);
    chk("abort_xq", xq.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_done", n_done, 0);

    // Full layer with choice = 1.
    xq.delete();
    pq.delete();
    oq.delete();
    clr_counts();
    choice = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push_kij(k);
      for (int i = 0; i < 36; i++) pq.push_back({1'b0, 11'(k * 36 + i)});
    end
    for (int o = 0; o < 16; o++) begin
      orow = o / 4;
      ocol = o % 4;
      for (int k = 0; k < 9; k++) begin
        ki = k / 3;
        kj = k % 3;
        if (o == 5) pq.push_back({1'b1, exp5[k]});
        else pq.push_back({1'b1,
          11'(k * 36 + (orow + ki) * 6 + ocol + kj)});
      end
      oq.push_back(4'(o));
    end
    @(negedge clk);
    chk("choice_bit", inst[34], 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("first_rd",
        {inst[19], inst[18], inst[17:7]},
        {1'b0, 1'b1, 11'h400});
    chk("run_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (1744) @(posedge clk);
    #1;
    chk("done_early", done, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_at_1749", done, 1);
    for (int i = 0; i < 3000 && n_done == 0; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("fin_start_busy", busy, 0);
    chk("fin_start_inst", inst, 35'h5_800C_0000);
    @(negedge clk);
    chk("done_latency", t_done - t_first, 1749);
    chk("xq_empty", xq.size(), 0);
    chk("pq_empty", pq.size(), 0);
    chk("oq_empty", oq.size(), 0);
    chk("n_l0wr", n_l0wr, 396);
    chk("n_load", n_load, 72);
    chk("n_exec", n_exec, 324);
    chk("n_ofrd", n_ofrd, 324);
    chk("n_acc", n_acc, 144);
    chk("n_creset", n_crst, 16);
    chk("n_done", n_done, 1);
    chk("n_ififo", n_ififo, 0);
    mon_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
